implication_queue: RTL and testbench

Buffers implications produced by `unit_clause_evaluator` (implied variable plus forced value, qualified by `is_unit_clause`) and issues them one at a time to the BCP/assignment controller. A per-variable pending table drops duplicate implications and detects a conflict: the same variable implied to opposite values while still pending. The block sits between the clause-evaluation stage and the variable-assignment writer in `sat_solver`.

---
 rtl/sat_pkg.sv | 13 +
 rtl/implication_fifo.sv | 59 +++++
 rtl/implication_queue.sv | 93 +++++++++
 tb/tb_implication_queue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Types and sizing shared by the evaluator, the implication queue and the
// assignment writer of sat_solver.
package sat_pkg;

    localparam int NUM_VARIABLE   = 128;
    localparam int VARIABLE_INDEX = $clog2(NUM_VARIABLE) - 1;

    typedef struct packed {
        logic [VARIABLE_INDEX:0] variable;
        logic                    val;
    } implication_t;

endpackage

// File: rtl/implication_fifo.sv
// Synchronous circular FIFO of implications with push/pop/clear and an
// occupancy count; the head reads as zero while the FIFO is empty.
module implication_fifo
    import sat_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  implication_t push_data,
    output implication_t head,
    output logic [AW:0]  count,
    output logic         empty,
    output logic         full
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    implication_t  mem [DEPTH];
    logic          push_en;
    logic          pop_en;

    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clock) begin
        if (push_en && !clear) mem[wr_ptr] <= push_data;
    end

    assign empty = (count == '0);
    assign full  = (count == (AW + 1)'(DEPTH));
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/implication_queue.sv
// Buffers implications from the clause evaluator, drops duplicates through a
// per-variable pending table and freezes on a contradictory implication.
module implication_queue
    import sat_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic [VARIABLE_INDEX:0]   in_variable,
    input  logic                      in_val,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [VARIABLE_INDEX:0]   out_variable,
    output logic                      out_val,
    input  logic                      out_ready,
    output logic                      conflict,
    output logic [VARIABLE_INDEX:0]   conflict_variable,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full
);

    logic [NUM_VARIABLE-1:0] pending;
    logic [NUM_VARIABLE-1:0] pending_val;
    implication_t            head;
    implication_t            in_entry;
    logic                    accept;
    logic                    pop;
    logic                    hit;
    logic                    enqueue;
    logic                    contradict;

    assign in_ready   = !full && !conflict;
    assign out_valid  = !empty && !conflict;
    assign accept     = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    // Classification always uses the table as it stood before this edge.
    assign hit        = pending[in_variable];
    assign enqueue    = accept && !hit;
    assign contradict = accept && hit && (pending_val[in_variable] != in_val);

    assign in_entry     = '{variable: in_variable, val: in_val};
    assign out_variable = head.variable;
    assign out_val      = head.val;

    implication_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (enqueue),
        .pop       (pop),
        .push_data (in_entry),
        .head      (head),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    // A popped head can never equal an enqueued variable (the head is pending),
    // so the set and the clear never target the same bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else if (clear) begin
            pending <= '0;
        end else begin
            if (enqueue) pending[in_variable]   <= 1'b1;
            if (pop)     pending[head.variable] <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (enqueue) pending_val[in_variable] <= in_val;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            conflict          <= 1'b0;
            conflict_variable <= '0;
        end else if (clear) begin
            conflict          <= 1'b0;
            conflict_variable <= '0;
        end else if (contradict) begin
            conflict          <= 1'b1;
            conflict_variable <= in_variable;
        end
    end

endmodule

// File: tb/tb_implication_queue.sv
// Directed self-checking bench for implication_queue.
module tb_implication_queue;
    import sat_pkg::*;

    logic                    clock;
    logic                    reset_n;
    logic                    clear;
    logic                    in_valid;
    logic [VARIABLE_INDEX:0] in_variable;
    logic                    in_val;
    logic                    in_ready;
    logic                    out_valid;
    logic [VARIABLE_INDEX:0] out_variable;
    logic                    out_val;
    logic                    out_ready;
    logic                    conflict;
    logic [VARIABLE_INDEX:0] conflict_variable;
    logic [4:0]              count;
    logic                    empty;
    logic                    full;

    int n_compared   = 0;
    int n_mismatched = 0;

    implication_queue #(.DEPTH(16)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .clear             (clear),
        .in_valid          (in_valid),
        .in_variable       (in_variable),
        .in_val            (in_val),
        .in_ready          (in_ready),
        .out_valid         (out_valid),
        .out_variable      (out_variable),
        .out_val           (out_val),
        .out_ready         (out_ready),
        .conflict          (conflict),
        .conflict_variable (conflict_variable),
        .count             (count),
        .empty             (empty),
        .full              (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input int v, input logic b);
        in_valid    = 1'b1;
        in_variable = v[VARIABLE_INDEX:0];
        in_val      = b;
        step();
        in_valid    = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_variable"}, 32'(out_variable), 0);
        chk({tag, "_out_val"}, 32'(out_val), 0);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_conflict"}, 32'(conflict), 0);
        chk({tag, "_conflict_variable"}, 32'(conflict_variable), 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        clear       = 1'b0;
        in_valid    = 1'b0;
        in_variable = '0;
        in_val      = 1'b0;
        out_ready   = 1'b0;
        #3;
        check_reset_values("reset");
        step();
        step();
        @(negedge clock);
        reset_n = 1'b1;

        // Single push then pop
        push_one(5, 1'b1);
        chk("push5_out_valid", 32'(out_valid), 1);
        chk("push5_out_variable", 32'(out_variable), 5);
        chk("push5_out_val", 32'(out_val), 1);
        chk("push5_count", 32'(count), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop5_empty", 32'(empty), 1);
        chk("pop5_out_valid", 32'(out_valid), 0);
        // pending[5] cleared: opposite value is accepted without conflict
        push_one(5, 1'b0);
        chk("repush5_count", 32'(count), 1);
        chk("repush5_conflict", 32'(conflict), 0);
        chk("repush5_out_val", 32'(out_val), 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Duplicate drop
        in_valid = 1'b1; in_variable = 7'd9; in_val = 1'b0;
        step();
        step();
        in_valid = 1'b0;
        chk("dup9_count", 32'(count), 1);
        chk("dup9_conflict", 32'(conflict), 0);

        // Conflict on 9, then clear
        push_one(9, 1'b1);
        chk("conf9_conflict", 32'(conflict), 1);
        chk("conf9_variable", 32'(conflict_variable), 9);
        chk("conf9_in_ready", 32'(in_ready), 0);
        chk("conf9_out_valid", 32'(out_valid), 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("conf9_frozen_count", 32'(count), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_conflict", 32'(conflict), 0);
        chk("clear_count", 32'(count), 0);
        chk("clear_in_ready", 32'(in_ready), 1);
        chk("clear_conflict_variable", 32'(conflict_variable), 0);

        // Advance pointers so the fill below wraps
        for (int i = 0; i < 5; i++) push_one(20 + i, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        out_ready = 1'b0;
        chk("pre_fill_empty", 32'(empty), 1);

        // Fill to 16
        for (int i = 0; i < 16; i++) push_one(40 + i, i[0]);
        chk("fill_full", 32'(full), 1);
        chk("fill_in_ready", 32'(in_ready), 0);
        chk("fill_count", 32'(count), 16);
        push_one(100, 1'b1);
        chk("offer17_count", 32'(count), 16);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_variable", i), 32'(out_variable), 32'(40 + i));
            chk($sformatf("drain%0d_val", i), 32'(out_val), 32'(i[0]));
            step();
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(empty), 1);
        chk("drain_out_valid", 32'(out_valid), 0);
        // 17th offer never became pending
        push_one(100, 1'b0);
        chk("post17_conflict", 32'(conflict), 0);
        chk("post17_count", 32'(count), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Pop of head 3 while (3,0) is offered
        push_one(3, 1'b1);
        out_ready = 1'b1;
        push_one(3, 1'b0);
        out_ready = 1'b0;
        chk("poppush3_conflict", 32'(conflict), 1);
        chk("poppush3_variable", 32'(conflict_variable), 3);
        chk("poppush3_count", 32'(count), 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        // Pop of head 3 while (3,1) is offered
        push_one(3, 1'b1);
        out_ready = 1'b1;
        push_one(3, 1'b1);
        out_ready = 1'b0;
        chk("popdup3_conflict", 32'(conflict), 0);
        chk("popdup3_count", 32'(count), 0);
        push_one(3, 1'b0);
        chk("after3_conflict", 32'(conflict), 0);
        chk("after3_count", 32'(count), 1);
        chk("after3_out_val", 32'(out_val), 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Async reset with entries queued and conflict set
        for (int i = 0; i < 4; i++) push_one(60 + i, 1'b1);
        push_one(61, 1'b0);
        chk("prereset_count", 32'(count), 4);
        chk("prereset_conflict", 32'(conflict), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        step();
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
